note_lane_engine: RTL and testbench
===================================

# note_lane_engine

Parametrised multi-lane falling-note engine for the rhythm-game datapath. Accepts note rows from the pattern sequencer over a valid/ready handshake and keeps up to SLOTS rows falling at once. Judges player key presses per lane as perfect, good or bad, and retires unplayed notes as misses. Maintains score, combo and miss counters, and produces per-lane sprite hits for the VGA compositor.

## Interface
Parameters:
- LANES, 4, number of lanes/keys; screen split into equal-width columns
- SLOTS, 4, note rows in flight simultaneously
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, row where notes retire
- TICK_DIV, 200000, CLOCK_25 cycles per 1-pixel fall step
- HIT_Y, 436, judgement line y
- GOOD_WIN, 16, good window half-width (pixels)
- PERFECT_WIN, 4, perfect window half-width (≤ GOOD_WIN)
- NOTE_H, 30, sprite height (even)
- SPAWN_GAP, 40, minimum y of the youngest row before the next spawn

Ports:
- CLOCK_25  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- key  in  LANES  raw player keys, active-high, asynchronous to clock
- pattern_in  in  LANES  lane mask of the next row
- pattern_valid  in  1  pattern_in is offered
- pattern_ready  out  1  engine accepts a row this cycle
- next_x, next_y  in  10 each  pixel being drawn
- sprite_lane  out  LANES  pixel lies inside a live note of that lane
- hit_perfect, hit_good, bad_press  out  LANES each  1-cycle judgement pulses
- miss_pulse  out  1  a retired row had ≥1 unhit lane
- score  out  16  saturating score
- combo  out  8  saturating combo
- miss_count  out  16  saturating count of missed notes

## Operation
- Slot state: valid, mask[LANES], hit[LANES], y[9:0]. Reset: all invalid, y=0. Counters and all pulse outputs are 0 on reset.
- Tick: prescaler counts 0..TICK_DIV-1. On wrap, every valid slot gets y+1.
- Retire: a valid slot with y ≥ SCREEN_H is cleared. Lanes with mask&~hit count as misses. miss_pulse=1 if that count is nonzero. miss_count adds popcount and saturates at 0xFFFF.
- Spawn: pattern_ready = (a free slot exists) && (no valid slot has y < SPAWN_GAP).
  - On valid&&ready, the lowest-index free slot loads mask=pattern_in, hit=0, y=0.
  - pattern_in==0 is consumed with no slot allocated (rest row).
- Keys: 2-flop synchroniser per lane, then rising-edge detect. Only edges are judged; a held key never judges again.
- Judgement per lane l on edge:
  - Candidates: valid slots with mask[l] && !hit[l] && |y−HIT_Y| ≤ GOOD_WIN.
  - The largest-y candidate is chosen; ties go to the lowest index. Its hit[l] is set.
  - hit_perfect[l] if |y−HIT_Y| ≤ PERFECT_WIN, else hit_good[l].
  - No candidate: bad_press[l].
  - Distance computed in 11-bit signed arithmetic.
- Score: +2 per perfect, +1 per good, summed over lanes in the cycle, saturating at 0xFFFF.
- Combo:
  - += number of lane hits in the cycle, saturating at 255.
  - Forced to 0 if any bad_press or miss_pulse occurs in the same cycle. Score still credits that cycle's hits.
- Sprite: sprite_lane[l]=1 if some valid slot has mask[l] && !hit[l] and the pixel falls in both:
  - next_x ∈ [l·SCREEN_W/LANES, (l+1)·SCREEN_W/LANES)
  - next_y+NOTE_H/2 ≥ y and next_y < y+NOTE_H/2
  - 11-bit compare, so there is no underflow near y=0.

## Timing
- sprite_lane is purely combinational from registered slot state and next_x/next_y.
- pattern_ready is combinational from registered state. A spawned slot is visible the cycle after acceptance.
- Key latency: key rising before edge k → judgement pulse registered at edge k+2, high for exactly one cycle.
- Same-cycle tick and judgement: judgement uses pre-tick y.
- Same-cycle retire and spawn: the retiring slot is not reused until the next cycle.
- A slot retired in the same cycle it is judged: the hit is recorded first, and the miss count excludes that lane.
- Reset asserted mid-fall clears slots, counters and synchroniser flops immediately. The prescaler restarts at 0.

## Test plan
- TICK_DIV=4, spawn mask 4'b0101 at cycle 0:
  - pattern_ready drops until y reaches SPAWN_GAP.
  - sprite_lane[0] and [2] assert at next_y=0, next_x=10 and next_x=330.
- Press key[2] when y=436 → hit_perfect[2] one cycle, score=2, combo=1. Press key[0] at y=447 → hit_good[0], score=3, combo=2.
- Press key[1] with no note in window → bad_press[1], combo=0, score unchanged.
- Row 4'b1111 left unplayed to y=480 → miss_pulse once, miss_count+=4, combo=0, slot freed next cycle.
- Two rows (y=430 and y=445) both holding lane 3 plus key[3] edge → y=445 slot is hit (good). A second edge while y=430 is still in window → hit on the y=430 slot.
- Fill all SLOTS → pattern_ready=0. Reset mid-fall → all outputs 0, pattern_ready=1 the next cycle.

Source files
------------

// File: rtl/note_lane_engine_if.sv
// Row handshake between the pattern sequencer and the note lane engine.
// The sequencer is the master; the engine is the slave.
interface note_lane_engine_if #(
    parameter int LANES = 4
);
    logic [LANES-1:0] pattern_in;
    logic             pattern_valid;
    logic             pattern_ready;

    modport master (
        output pattern_in,
        output pattern_valid,
        input  pattern_ready
    );

    modport slave (
        input  pattern_in,
        input  pattern_valid,
        output pattern_ready
    );
endinterface

// File: rtl/note_lane_engine.sv
// note_lane_engine: falling-note rows, per-lane key judgement,
// score/combo/miss counters and per-lane sprite hits.
module note_lane_engine #(
    parameter int LANES       = 4,
    parameter int SLOTS       = 4,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int TICK_DIV    = 200000,
    parameter int HIT_Y       = 436,
    parameter int GOOD_WIN    = 16,
    parameter int PERFECT_WIN = 4,
    parameter int NOTE_H      = 30,
    parameter int SPAWN_GAP   = 40
) (
    input  logic              CLOCK_25,
    input  logic              reset,
    input  logic [LANES-1:0]  key,
    note_lane_engine_if.slave pat,
    input  logic [9:0]        next_x,
    input  logic [9:0]        next_y,
    output logic [LANES-1:0]  sprite_lane,
    output logic [LANES-1:0]  hit_perfect,
    output logic [LANES-1:0]  hit_good,
    output logic [LANES-1:0]  bad_press,
    output logic              miss_pulse,
    output logic [15:0]       score,
    output logic [7:0]        combo,
    output logic [15:0]       miss_count
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int HH = NOTE_H / 2;
    localparam logic signed [10:0] HY = 11'(HIT_Y);

    logic [PW-1:0]        r_presc;
    logic                 w_tick;
    logic [LANES-1:0]     r_s1, r_s2, r_s3, w_edge;
    logic [SLOTS-1:0]     r_valid;
    logic [LANES-1:0]     r_mask [SLOTS];
    logic [LANES-1:0]     r_hit [SLOTS];
    logic [9:0]           r_y [SLOTS];
    logic [LANES-1:0]     w_hit_nx [SLOTS];
    logic signed [10:0]   w_dist [SLOTS];
    logic [10:0]          w_adist [SLOTS];
    logic [SLOTS-1:0]     w_ret;
    logic [LANES-1:0]     w_perf, w_good, w_bad;
    logic [15:0]          w_miss_n;
    logic                 w_young, w_has_free, w_ready, w_acc;
    logic [SW-1:0]        w_free_idx;
    logic [15:0]          w_pts;
    logic [7:0]           w_nhits;
    logic [16:0]          w_score_sum, w_miss_sum;
    logic [8:0]           w_combo_sum;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));
    assign w_edge = r_s2 & ~r_s3;
    assign pat.pattern_ready = w_ready;

    // Signed distance of each slot from the judgement line, and its magnitude.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            w_dist[s]  = signed'({1'b0, r_y[s]}) - HY;
            w_adist[s] = w_dist[s][10] ? unsigned'(-w_dist[s])
                                       : unsigned'(w_dist[s]);
        end
    end

    // Per-lane judgement: lowest (largest-y) unhit note in the good window.
    always_comb begin : judge
        logic          found;
        logic [SW-1:0] sel;
        logic [9:0]    besty;
        w_perf = '0;
        w_good = '0;
        w_bad  = '0;
        found  = 1'b0;
        sel    = '0;
        besty  = '0;
        for (int s = 0; s < SLOTS; s++) w_hit_nx[s] = r_hit[s];
        for (int l = 0; l < LANES; l++) begin
            found = 1'b0;
            sel   = '0;
            besty = '0;
            for (int s = 0; s < SLOTS; s++) begin
                if (r_valid[s] && r_mask[s][l] && !r_hit[s][l]
                    && w_adist[s] <= 11'(GOOD_WIN)
                    && (!found || r_y[s] > besty)) begin
                    found = 1'b1;
                    sel   = SW'(s);
                    besty = r_y[s];
                end
            end
            if (w_edge[l]) begin
                if (found) begin
                    w_hit_nx[sel][l] = 1'b1;
                    if (w_adist[sel] <= 11'(PERFECT_WIN)) w_perf[l] = 1'b1;
                    else w_good[l] = 1'b1;
                end else begin
                    w_bad[l] = 1'b1;
                end
            end
        end
    end

    // Retirement and missed-lane count; this cycle's hits are excluded.
    always_comb begin
        w_ret    = '0;
        w_miss_n = '0;
        for (int s = 0; s < SLOTS; s++) begin
            w_ret[s] = r_valid[s] && (r_y[s] >= 10'(SCREEN_H));
            for (int l = 0; l < LANES; l++) begin
                if (w_ret[s] && r_mask[s][l] && !w_hit_nx[s][l])
                    w_miss_n = w_miss_n + 16'd1;
            end
        end
    end

    // Spawn gating and lowest-index free slot selection.
    always_comb begin
        w_young    = 1'b0;
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (r_valid[s] && r_y[s] < 10'(SPAWN_GAP)) w_young = 1'b1;
            if (!r_valid[s]) begin
                w_has_free = 1'b1;
                w_free_idx = SW'(s);
            end
        end
        w_ready = w_has_free && !w_young;
        w_acc   = pat.pattern_valid && w_ready && (|pat.pattern_in);
    end

    // Points and hit count for this cycle, with saturating sums.
    always_comb begin
        w_pts   = '0;
        w_nhits = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pts   = w_pts + (w_perf[l] ? 16'd2 : 16'd0)
                            + (w_good[l] ? 16'd1 : 16'd0);
            w_nhits = w_nhits + {7'd0, w_perf[l] | w_good[l]};
        end
        w_score_sum = {1'b0, score} + {1'b0, w_pts};
        w_miss_sum  = {1'b0, miss_count} + {1'b0, w_miss_n};
        w_combo_sum = {1'b0, combo} + {1'b0, w_nhits};
    end

    // Sprite hit test against every live, unhit note (11-bit, no underflow).
    always_comb begin
        sprite_lane = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (r_valid[s] && r_mask[s][l] && !r_hit[s][l]
                    && {1'b0, next_x} >= 11'(l * SCREEN_W / LANES)
                    && {1'b0, next_x} < 11'((l + 1) * SCREEN_W / LANES)
                    && {1'b0, next_y} + 11'(HH) >= {1'b0, r_y[s]}
                    && {1'b0, next_y} < {1'b0, r_y[s]} + 11'(HH))
                    sprite_lane[l] = 1'b1;
            end
        end
    end

    // Fall prescaler and key synchroniser / edge history.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_s1    <= key;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
        end
    end

    // Slot state: retire first, then hit/fall for live slots, then spawn.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                r_mask[s] <= '0;
                r_hit[s]  <= '0;
                r_y[s]    <= '0;
            end
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (w_ret[s]) begin
                    r_valid[s] <= 1'b0;
                    r_mask[s]  <= '0;
                    r_hit[s]   <= '0;
                    r_y[s]     <= '0;
                end else if (r_valid[s]) begin
                    r_hit[s] <= w_hit_nx[s];
                    if (w_tick) r_y[s] <= r_y[s] + 10'd1;
                end else if (w_acc && w_free_idx == SW'(s)) begin
                    r_valid[s] <= 1'b1;
                    r_mask[s]  <= pat.pattern_in;
                    r_hit[s]   <= '0;
                    r_y[s]     <= '0;
                end
            end
        end
    end

    // Judgement pulses and saturating score/combo/miss counters.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            hit_perfect <= '0;
            hit_good    <= '0;
            bad_press   <= '0;
            miss_pulse  <= 1'b0;
            score       <= '0;
            combo       <= '0;
            miss_count  <= '0;
        end else begin
            hit_perfect <= w_perf;
            hit_good    <= w_good;
            bad_press   <= w_bad;
            miss_pulse  <= (w_miss_n != 16'd0);
            score       <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            miss_count  <= w_miss_sum[16] ? 16'hFFFF : w_miss_sum[15:0];
            if (|w_bad || w_miss_n != 16'd0) combo <= '0;
            else combo <= w_combo_sum[8] ? 8'hFF : w_combo_sum[7:0];
        end
    end
endmodule

// File: tb/tb_note_lane_engine.sv
// Directed bench for note_lane_engine with TICK_DIV=4 and SPAWN_GAP=15,
// so rows can sit 15 pixels apart near the judgement line.
`timescale 1ns/100ps
module tb_note_lane_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key;
    logic [9:0]  next_x, next_y;
    logic [3:0]  sprite_lane, hit_perfect, hit_good, bad_press;
    logic        miss_pulse;
    logic [15:0] score, miss_count;
    logic [7:0]  combo;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] exp;
    } spr_vec_t;

    spr_vec_t tbl [12];

    note_lane_engine_if #(.LANES(4)) pif ();

    note_lane_engine #(
        .LANES(4), .SLOTS(4), .SCREEN_W(640), .SCREEN_H(480),
        .TICK_DIV(4), .HIT_Y(436), .GOOD_WIN(16), .PERFECT_WIN(4),
        .NOTE_H(30), .SPAWN_GAP(15)
    ) dut (
        .CLOCK_25(clk),
        .reset(reset),
        .key(key),
        .pat(pif.slave),
        .next_x(next_x),
        .next_y(next_y),
        .sprite_lane(sprite_lane),
        .hit_perfect(hit_perfect),
        .hit_good(hit_good),
        .bad_press(bad_press),
        .miss_pulse(miss_pulse),
        .score(score),
        .combo(combo),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Bench-side cycle count since reset release; edge n gives y = n/4
    // for a row accepted at edge 1.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
        chk("sched", 32'(cyc), 32'(n));
    endtask

    task automatic chk_pulses(input string nm, input logic [3:0] p,
                              input logic [3:0] g, input logic [3:0] b);
        chk({nm, "_perf"}, 32'(hit_perfect), 32'(p));
        chk({nm, "_good"}, 32'(hit_good), 32'(g));
        chk({nm, "_bad"}, 32'(bad_press), 32'(b));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{10'd10,  10'd0,  4'b0001};
        tbl[1]  = '{10'd330, 10'd0,  4'b0100};
        tbl[2]  = '{10'd170, 10'd0,  4'b0000};
        tbl[3]  = '{10'd10,  10'd14, 4'b0001};
        tbl[4]  = '{10'd10,  10'd15, 4'b0000};
        tbl[5]  = '{10'd639, 10'd0,  4'b0000};
        tbl[6]  = '{10'd159, 10'd0,  4'b0001};
        tbl[7]  = '{10'd160, 10'd0,  4'b0000};
        tbl[8]  = '{10'd320, 10'd5,  4'b0100};
        tbl[9]  = '{10'd319, 10'd5,  4'b0000};
        tbl[10] = '{10'd479, 10'd0,  4'b0100};
        tbl[11] = '{10'd480, 10'd0,  4'b0000};

        reset = 1'b1;
        key = '0;
        pif.pattern_in = '0;
        pif.pattern_valid = 1'b0;
        next_x = '0;
        next_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(pif.pattern_ready), 32'd1);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_combo", 32'(combo), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_mpulse", 32'(miss_pulse), 32'd0);
        chk_pulses("rst", 4'b0000, 4'b0000, 4'b0000);
        chk("rst_sprite", 32'(sprite_lane), 32'd0);

        // Row A (lanes 0,2) accepted at edge 1.
        pif.pattern_in = 4'b0101;
        pif.pattern_valid = 1'b1;
        reset = 1'b0;
        run_to(1);
        pif.pattern_valid = 1'b0;
        chk("ready_after_spawn", 32'(pif.pattern_ready), 32'd0);

        for (int i = 0; i < 12; i++) begin
            next_x = tbl[i].x;
            next_y = tbl[i].y;
            #0.5;
            chk($sformatf("sprite%0d", i), 32'(sprite_lane), 32'(tbl[i].exp));
        end

        run_to(59);
        chk("ready_y14", 32'(pif.pattern_ready), 32'd0);
        run_to(60);
        chk("ready_y15", 32'(pif.pattern_ready), 32'd1);

        // Row B (all lanes) accepted at edge 161, 40 px behind row A.
        run_to(160);
        pif.pattern_in = 4'b1111;
        pif.pattern_valid = 1'b1;
        run_to(161);
        pif.pattern_valid = 1'b0;
        chk("ready_after_b", 32'(pif.pattern_ready), 32'd0);

        // Lane 1 press with nothing in window.
        run_to(999);
        key[1] = 1'b1;
        run_to(1002);
        chk_pulses("bad1", 4'b0000, 4'b0000, 4'b0010);
        chk("bad1_score", 32'(score), 32'd0);
        chk("bad1_combo", 32'(combo), 32'd0);
        run_to(1010);
        key[1] = 1'b0;

        // Lane 2 judged at y=436: perfect.
        run_to(1743);
        key[2] = 1'b1;
        run_to(1745);
        chk_pulses("perf_early", 4'b0000, 4'b0000, 4'b0000);
        step();
        chk_pulses("perf2", 4'b0100, 4'b0000, 4'b0000);
        chk("perf2_score", 32'(score), 32'd2);
        chk("perf2_combo", 32'(combo), 32'd1);
        step();
        chk_pulses("perf2_end", 4'b0000, 4'b0000, 4'b0000);

        run_to(1750);
        next_x = 10'd10;
        next_y = 10'd437;
        #0.5;
        chk("spr_lane0_live", 32'(sprite_lane), 32'd1);
        next_x = 10'd330;
        #0.5;
        chk("spr_lane2_hit", 32'(sprite_lane), 32'd0);

        // Lane 0 judged at y=447: good.
        run_to(1787);
        key[0] = 1'b1;
        run_to(1790);
        chk_pulses("good0", 4'b0000, 4'b0001, 4'b0000);
        chk("good0_score", 32'(score), 32'd3);
        chk("good0_combo", 32'(combo), 32'd2);
        run_to(1795);
        key = '0;

        // Row A fully hit: retires silently.
        run_to(1921);
        chk("retA_mpulse", 32'(miss_pulse), 32'd0);
        chk("retA_miss", 32'(miss_count), 32'd0);
        chk("retA_combo", 32'(combo), 32'd2);

        // Row B unplayed: four misses, combo cleared.
        run_to(2080);
        chk("retB_pre", 32'(miss_pulse), 32'd0);
        run_to(2081);
        chk("retB_mpulse", 32'(miss_pulse), 32'd1);
        chk("retB_miss", 32'(miss_count), 32'd4);
        chk("retB_combo", 32'(combo), 32'd0);
        chk("retB_score", 32'(score), 32'd3);
        step();
        chk("retB_mpulse_end", 32'(miss_pulse), 32'd0);

        // Rows C (edge 2101) and D (edge 2161) both on lane 3, 15 px apart.
        run_to(2100);
        pif.pattern_in = 4'b1000;
        pif.pattern_valid = 1'b1;
        run_to(2101);
        pif.pattern_valid = 1'b0;
        run_to(2160);
        chk("ready_c_y15", 32'(pif.pattern_ready), 32'd1);
        pif.pattern_valid = 1'b1;
        run_to(2161);
        pif.pattern_valid = 1'b0;

        // C at 445, D at 430: the lower row C is taken (good).
        run_to(3879);
        key[3] = 1'b1;
        run_to(3882);
        chk_pulses("l3_first", 4'b0000, 4'b1000, 4'b0000);
        chk("l3_first_score", 32'(score), 32'd4);
        chk("l3_first_combo", 32'(combo), 32'd1);
        run_to(3884);
        key[3] = 1'b0;

        // C at 447 (already hit), D at 432: D judged perfect.
        run_to(3887);
        key[3] = 1'b1;
        run_to(3890);
        chk_pulses("l3_second", 4'b1000, 4'b0000, 4'b0000);
        chk("l3_second_score", 32'(score), 32'd6);
        chk("l3_second_combo", 32'(combo), 32'd2);

        run_to(3899);
        key[1] = 1'b1;
        run_to(3902);
        chk_pulses("bad2", 4'b0000, 4'b0000, 4'b0010);
        chk("bad2_combo", 32'(combo), 32'd0);
        chk("bad2_score", 32'(score), 32'd6);
        key = '0;

        run_to(4100);
        chk("retCD_miss", 32'(miss_count), 32'd4);
        chk("ready_empty", 32'(pif.pattern_ready), 32'd1);

        // Rest row: consumed, no slot taken.
        pif.pattern_in = 4'b0000;
        pif.pattern_valid = 1'b1;
        step();
        pif.pattern_valid = 1'b0;
        chk("rest_ready", 32'(pif.pattern_ready), 32'd1);

        // Fill every slot.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 200 && !pif.pattern_ready; i++) step();
            chk($sformatf("fill_wait%0d", r), 32'(pif.pattern_ready), 32'd1);
            pif.pattern_in = 4'b0001;
            pif.pattern_valid = 1'b1;
            step();
            pif.pattern_valid = 1'b0;
        end
        repeat (100) step();
        chk("full_ready", 32'(pif.pattern_ready), 32'd0);

        // Reset mid-fall clears everything at once.
        reset = 1'b1;
        #1;
        chk("mid_rst_score", 32'(score), 32'd0);
        chk("mid_rst_miss", 32'(miss_count), 32'd0);
        chk("mid_rst_combo", 32'(combo), 32'd0);
        chk("mid_rst_ready", 32'(pif.pattern_ready), 32'd1);
        next_x = 10'd10;
        next_y = 10'd20;
        #0.5;
        chk("mid_rst_sprite", 32'(sprite_lane), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("post_rst_ready", 32'(pif.pattern_ready), 32'd1);
        chk_pulses("post_rst", 4'b0000, 4'b0000, 4'b0000);
        chk("post_rst_mpulse", 32'(miss_pulse), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
